// File: rtl/fir_axil_pkg.sv
// Shared types and constants for the FIR AXI4-Lite register slave.
package fir_axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  localparam int REG_IDX_W = 3;

  localparam logic [4:0] REG0_OFF = 5'h00;
  localparam logic [4:0] REG1_OFF = 5'h04;
  localparam logic [4:0] REG2_OFF = 5'h08;
  localparam logic [4:0] REG3_OFF = 5'h0C;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) v[8*b +: 8] = new_v[8*b +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/fir_axil_slave_regs.sv
// AXI4-Lite slave holding the FIR control/coefficient registers.
// Independent write and read channels, one outstanding each.
module fir_axil_slave_regs
  import fir_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_REGS         = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [3:0]                      S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [32*C_NUM_REGS-1:0]        regs_o,
  output logic [C_NUM_REGS-1:0]           reg_wr_pulse_o
);

  localparam logic [4:0] C_OFFS [4] = '{
    REG0_OFF, REG1_OFF, REG2_OFF, REG3_OFF
  };

  logic                 r_active;
  wr_state_t            r_wst;
  wr_state_t            w_wst_nxt;
  rd_state_t            r_rst;
  rd_state_t            w_rst_nxt;
  logic [REG_IDX_W-1:0] r_aw_idx;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic [31:0]          r_regs [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] r_pulse;
  resp_t                r_bresp;
  resp_t                r_rresp;
  logic [31:0]          r_rdata;

  logic                 w_awready;
  logic                 w_wready;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_commit;
  logic [REG_IDX_W-1:0] w_widx;
  logic [31:0]          w_wdata;
  logic [3:0]           w_wstrb;
  logic [C_NUM_REGS-1:0] w_wsel;
  logic                 w_whit;
  logic                 w_arready;
  logic                 w_ar_hs;
  logic [REG_IDX_W-1:0] w_ridx;
  logic [31:0]          w_rval;
  logic                 w_rhit;

  logic w_unused;
  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_aw_hs = S_AXI_AWVALID && w_awready;
  assign w_w_hs  = S_AXI_WVALID && w_wready;
  assign w_ar_hs = S_AXI_ARVALID && w_arready;

  // Address/data come from the captured copy only when that half arrived earlier.
  assign w_widx  = (r_wst == W_HAVE_A) ? r_aw_idx : S_AXI_AWADDR[4:2];
  assign w_wdata = (r_wst == W_HAVE_D) ? r_wdata  : S_AXI_WDATA;
  assign w_wstrb = (r_wst == W_HAVE_D) ? r_wstrb  : S_AXI_WSTRB;
  assign w_ridx  = S_AXI_ARADDR[4:2];

  always_comb begin
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_commit  = 1'b0;
    w_wst_nxt = r_wst;
    unique case (r_wst)
      W_IDLE: begin
        w_awready = r_active;
        w_wready  = r_active;
        if (w_aw_hs && w_w_hs) begin
          w_commit  = 1'b1;
          w_wst_nxt = W_RESP;
        end else if (w_aw_hs) begin
          w_wst_nxt = W_HAVE_A;
        end else if (w_w_hs) begin
          w_wst_nxt = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        w_wready = 1'b1;
        if (w_w_hs) begin
          w_commit  = 1'b1;
          w_wst_nxt = W_RESP;
        end
      end
      W_HAVE_D: begin
        w_awready = 1'b1;
        if (w_aw_hs) begin
          w_commit  = 1'b1;
          w_wst_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_wst_nxt = W_IDLE;
      end
      default: w_wst_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_arready = 1'b0;
    w_rst_nxt = r_rst;
    unique case (r_rst)
      R_IDLE: begin
        w_arready = r_active;
        if (w_ar_hs) w_rst_nxt = R_DATA;
      end
      R_DATA: begin
        if (S_AXI_RREADY) w_rst_nxt = R_IDLE;
      end
      default: w_rst_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_wsel = '0;
    w_rval = '0;
    w_rhit = 1'b0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      w_wsel[k] = (w_widx == C_OFFS[k][4:2]);
      if (w_ridx == C_OFFS[k][4:2]) begin
        w_rval = r_regs[k];
        w_rhit = 1'b1;
      end
    end
  end

  assign w_whit = |w_wsel;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_active <= 1'b0;
      r_wst    <= W_IDLE;
      r_rst    <= R_IDLE;
      r_aw_idx <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else begin
      r_active <= 1'b1;
      r_wst    <= w_wst_nxt;
      r_rst    <= w_rst_nxt;
      if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[4:2];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= w_whit ? RESP_OKAY : RESP_SLVERR;
      if (w_ar_hs) begin
        r_rdata <= w_rval;
        r_rresp <= w_rhit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < C_NUM_REGS; k++) r_regs[k] <= '0;
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (w_commit && w_wsel[k]) begin
          r_regs[k]  <= apply_strb(r_regs[k], w_wdata, w_wstrb);
          r_pulse[k] <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_regs
    assign regs_o[32*k +: 32] = r_regs[k];
  end

  assign S_AXI_AWREADY  = w_awready;
  assign S_AXI_WREADY   = w_wready;
  assign S_AXI_BVALID   = (r_wst == W_RESP);
  assign S_AXI_BRESP    = r_bresp;
  assign S_AXI_ARREADY  = w_arready;
  assign S_AXI_RVALID   = (r_rst == R_DATA);
  assign S_AXI_RDATA    = r_rdata;
  assign S_AXI_RRESP    = r_rresp;
  assign reg_wr_pulse_o = r_pulse;

endmodule

// File: tb/tb_fir_axil_slave_regs.sv
// Directed self-checking bench for fir_axil_slave_regs.
module tb_fir_axil_slave_regs;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [4:0]   S_AXI_AWADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b0;
  logic [4:0]   S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_ARPROT = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b0;
  logic [127:0] regs_o;
  logic [3:0]   reg_wr_pulse_o;

  int n_assert = 0;
  int n_fail   = 0;
  int pcnt [4] = '{0, 0, 0, 0};

  always #5 ACLK = ~ACLK;

  fir_axil_slave_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o), .reg_wr_pulse_o(reg_wr_pulse_o)
  );

  always @(negedge ACLK) begin
    for (int k = 0; k < 4; k++) pcnt[k] += int'(reg_wr_pulse_o[k]);
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit ad = 0, wd = 0, got = 0;
    logic ra, rw;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    resp = 2'bxx;
    for (int i = 0; i < 20 && !got; i++) begin
      ra = S_AXI_AWREADY && S_AXI_AWVALID;
      rw = S_AXI_WREADY && S_AXI_WVALID;
      @(negedge ACLK);
      if (ra) begin S_AXI_AWVALID = 1'b0; ad = 1; end
      if (rw) begin S_AXI_WVALID = 1'b0; wd = 1; end
      if (ad && wd && S_AXI_BVALID) begin
        resp = S_AXI_BRESP; got = 1;
      end
    end
    chk("write_done", {127'b0, got}, 128'd1);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    bit ad = 0, got = 0;
    logic ra;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    d = 'x; resp = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      ra = S_AXI_ARREADY && S_AXI_ARVALID;
      @(negedge ACLK);
      if (ra) begin S_AXI_ARVALID = 1'b0; ad = 1; end
      if (ad && S_AXI_RVALID) begin
        d = S_AXI_RDATA; resp = S_AXI_RRESP; got = 1;
      end
    end
    chk("read_done", {127'b0, got}, 128'd1);
    S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  logic [127:0] snap;
  int pc0 [4];

  initial begin
    #12;
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_regs", regs_o, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rel_awready", S_AXI_AWREADY, 1);
    chk("rel_arready", S_AXI_ARREADY, 1);

    // 1. sequential write then read
    for (int k = 0; k < 4; k++) begin
      axi_write(5'(4*k), 32'(k+1), 4'hF, resp);
      chk("t1_bresp", resp, 2'b00);
    end
    for (int k = 0; k < 4; k++) begin
      axi_read(5'(4*k), rd, resp);
      chk("t1_rresp", resp, 2'b00);
      chk("t1_rdata", rd, 32'(k+1));
    end
    chk("t1_regs", regs_o,
        128'h00000004_00000003_00000002_00000001);
    for (int k = 0; k < 4; k++) chk("t1_pulses", pcnt[k], 1);

    // 2. partial strobe
    axi_write(5'h04, 32'h11223344, 4'hF, resp);
    axi_write(5'h04, 32'hAABBCCDD, 4'b0101, resp);
    axi_read(5'h04, rd, resp);
    chk("t2_rdata", rd, 32'h11BB33DD);

    // 3a. AW three cycles before W
    @(negedge ACLK);
    S_AXI_BREADY = 1'b1;
    S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3a_awready_gap", S_AXI_AWREADY, 0);
      chk("t3a_wready_gap", S_AXI_WREADY, 1);
      @(negedge ACLK);
    end
    S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    chk("t3a_bvalid", S_AXI_BVALID, 1);
    chk("t3a_reg2", regs_o[64 +: 32], 32'hCAFEF00D);
    @(negedge ACLK);
    chk("t3a_bdone", S_AXI_BVALID, 0);

    // 3b. W first
    S_AXI_WDATA = 32'h12345678; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3b_wready_gap", S_AXI_WREADY, 0);
      chk("t3b_awready_gap", S_AXI_AWREADY, 1);
      chk("t3b_no_commit", regs_o[64 +: 32], 32'hCAFEF00D);
      @(negedge ACLK);
    end
    S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    chk("t3b_bvalid", S_AXI_BVALID, 1);
    chk("t3b_reg2", regs_o[64 +: 32], 32'h12345678);
    @(negedge ACLK);

    // 4. backpressure on B and R
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h0BADBEEF;
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid", S_AXI_BVALID, 1);
      chk("t4_bresp", S_AXI_BRESP, 2'b00);
      chk("t4_rvalid", S_AXI_RVALID, 1);
      chk("t4_rdata", S_AXI_RDATA, 32'h11BB33DD);
      chk("t4_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
      chk("t4_reg3_hold", regs_o[96 +: 32], 32'h4);
      @(negedge ACLK);
    end
    chk("t4_reg0", regs_o[31:0], 32'hA5A5A5A5);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    chk("t4_b_released", S_AXI_BVALID, 0);
    chk("t4_aw_ready_again", S_AXI_AWREADY, 1);
    chk("t4_r_released", S_AXI_RVALID, 0);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("t4_new_bvalid", S_AXI_BVALID, 1);
    chk("t4_reg3", regs_o[96 +: 32], 32'h0BADBEEF);
    @(negedge ACLK);

    // read captured on the same edge as a write commit sees old data
    S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h5A5A0000; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("same_edge_rdata", S_AXI_RDATA, 32'hA5A5A5A5);
    chk("same_edge_reg0", regs_o[31:0], 32'h5A5A0000);
    @(negedge ACLK);

    // 5. out of range
    snap = regs_o;
    pc0 = pcnt;
    axi_write(5'h10, 32'hFFFFFFFF, 4'hF, resp);
    chk("t5_bresp", resp, 2'b10);
    axi_read(5'h1C, rd, resp);
    chk("t5_rresp", resp, 2'b10);
    chk("t5_rdata", rd, 32'h0);
    chk("t5_regs", regs_o, snap);
    for (int k = 0; k < 4; k++) chk("t5_no_pulse", pcnt[k], pc0[k]);

    // 6. reset mid-operation
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h77777777; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("t6_pre_bvalid", S_AXI_BVALID, 1);
    chk("t6_pre_rvalid", S_AXI_RVALID, 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("t6_bvalid", S_AXI_BVALID, 0);
    chk("t6_rvalid", S_AXI_RVALID, 0);
    chk("t6_regs", regs_o, 0);
    chk("t6_rdata", S_AXI_RDATA, 0);
    chk("t6_awready", S_AXI_AWREADY, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("t6_rel_ready_low", S_AXI_AWREADY, 0);
    @(negedge ACLK);
    chk("t6_readys", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    chk("t6_no_replay", S_AXI_BVALID, 0);
    axi_read(5'h04, rd, resp);
    chk("t6_read0", rd, 32'h0);
    chk("t6_read0_resp", resp, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_axil_slave_regs.md
Name: fir_axil_slave_regs

Overview:
AXI4-Lite responder (slave) for the FIR peripheral's S00_AXI port: the register-file end of the link that the master VIP drives with AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST. It holds 4 x 32-bit read/write registers (FIR control/coefficient words) at offsets 0x0, 0x4, 0x8 and 0xC, and exposes them to the FIR core. One outstanding write and one outstanding read; the write and read channels run independently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte-address width; decoded window is 0x00-0x1F.
C_NUM_REGS, 4, implemented registers at word offsets 0..C_NUM_REGS-1.

Ports:
ACLK  in  1  single clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  5  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response (OKAY=00, SLVERR=10)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  5  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
regs_o  out  128  register contents, reg[k] at bits [32k+31:32k]
reg_wr_pulse_o  out  4  one-cycle pulse per register on each committed write

Behaviour:
- Reset is asynchronous and active-low (ARESETN). While ARESETN=0: all registers 0, every output 0 (including all READY/VALID, BRESP, RRESP, RDATA), both FSMs in idle. READYs rise on the first ACLK edge after release. Reset mid-transaction drops any pending response; nothing is replayed.
- Decode: index = ADDR[4:2], ADDR[1:0] ignored. An index below C_NUM_REGS hits a register; indices 4..7 are out of range.
- Write FSM states: W_IDLE (AWREADY=1, WREADY=1), W_HAVE_A (AW captured, AWREADY=0, WREADY=1), W_HAVE_D (W captured, AWREADY=1, WREADY=0), W_RESP (both READYs 0, BVALID=1).
  - AW and W handshaking in the same cycle: W_IDLE -> W_RESP.
  - AW only: -> W_HAVE_A, then -> W_RESP on the W handshake. W only: mirror case through W_HAVE_D.
- Write commit happens at the edge that completes the address+data pair. Each byte b with WSTRB[b]=1 is updated, so regs_o changes and reg_wr_pulse_o[index] is high in the following cycle. BVALID is asserted in that same following cycle.
- BRESP=OKAY on a hit. BRESP=SLVERR on out of range, with no register change and no pulse.
- BVALID and BRESP hold until BREADY=1. W_RESP -> W_IDLE on the handshake; READYs return the next cycle. Minimum write cycle is 2 clocks.
- Read FSM states: R_IDLE (ARREADY=1), R_DATA (ARREADY=0, RVALID=1). RDATA/RRESP are registered on the AR handshake edge and RVALID rises the next cycle (latency 1). They hold until RREADY=1, then the FSM returns to R_IDLE.
- Out-of-range read: RDATA=0, RRESP=SLVERR.
- Simultaneous events: if a read is captured on the same edge as a write commit to the same register, the read returns the pre-write value. Write and read channels never stall each other.
- PROT inputs are ignored.

Decomposition:
- Package fir_axil_pkg holds:
  - resp_t constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - localparam REG_IDX_W=3;
  - enums wr_state_t and rd_state_t;
  - register offset constants REG0_OFF..REG3_OFF = 0x0/0x4/0x8/0xC.
- Single module, no sub-module. The byte-strobe merge is a function in the package.

Test Plan:
1. Sequential-write-then-read, the same flow the S00_AXI example test runs: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with WSTRB=F, then read back -> every BRESP/RRESP=OKAY, RDATA=0x1..0x4, regs_o=0x00000004_00000003_00000002_00000001, one pulse per write.
2. Partial strobe: reg1=0x11223344, then write 0xAABBCCDD with WSTRB=0101 to 0x4 -> read returns 0x11BB33DD.
3. Split channels: AWVALID(0x8) asserted 3 cycles before WVALID(0xCAFEF00D) -> AWREADY=0 and WREADY=1 in the gap, BVALID 1 cycle after the W handshake, reg2=0xCAFEF00D. Repeat with W first.
4. Backpressure: BREADY and RREADY held low 5 cycles -> BVALID/RVALID, BRESP, RDATA stay stable for all 5 cycles, AWREADY/WREADY/ARREADY stay 0, and a new AW is not accepted until after the B handshake.
5. Out of range: write 0xFFFFFFFF to 0x10 and read 0x1C -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no regs_o change, no pulse.
6. Reset mid-operation: assert ARESETN=0 while BVALID=1 and a read is pending -> BVALID, RVALID and regs_o are 0 immediately (asynchronous); READYs are 1 on the first edge after release; reads return 0.
